// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers and MTHI/MTLO writes
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             mthiE,
  input  logic             mtloE,
  input  logic             abortE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, nextState;
  logic [CW-1:0] count;
  logic [1:0] op;
  logic signA, signB;
  logic [WIDTH-1:0] aMag, bMag, accHi, accLo, origA, magA, magB, stepHi, stepLo, quot, rem;
  logic [WIDTH:0] mulSum, divTrial;
  logic [2*WIDTH-1:0] prod;
  logic divFits, negRes;
  always_comb begin
    nextState = state == IDLE ? ((startE && !abortE) ? RUN : IDLE)
              : abortE ? IDLE
              : state == RUN ? ((count == CW'(1)) ? FIN : RUN)
              : IDLE;
    magA = (!opE[0] && srcaE[WIDTH-1]) ? -srcaE : srcaE;
    magB = (!opE[0] && srcbE[WIDTH-1]) ? -srcbE : srcbE;
    mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, aMag} : '0);
    divTrial = {accHi, accLo[WIDTH-1]} - {1'b0, bMag};
    divFits = !divTrial[WIDTH];
    stepHi = op[1] ? (divFits ? divTrial[WIDTH-1:0] : {accHi[WIDTH-2:0], accLo[WIDTH-1]}) : mulSum[WIDTH:1];
    stepLo = op[1] ? {accLo[WIDTH-2:0], divFits} : {mulSum[0], accLo[WIDTH-1:1]};
    negRes = !op[0] && (signA ^ signB);
    prod = negRes ? -{accHi, accLo} : {accHi, accLo};
    quot = negRes ? -accLo : accLo;
    rem = (!op[0] && signA) ? -accHi : accHi;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nextState;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      op <= '0;
      signA <= 1'b0;
      signB <= 1'b0;
      aMag <= '0;
      bMag <= '0;
      accHi <= '0;
      accLo <= '0;
      origA <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && startE && !abortE) begin
        count <= CW'(WIDTH);
        op <= opE;
        signA <= !opE[0] && srcaE[WIDTH-1];
        signB <= !opE[0] && srcbE[WIDTH-1];
        aMag <= magA;
        bMag <= magB;
        origA <= srcaE;
        accHi <= '0;
        accLo <= opE[1] ? magA : magB;
      end else if (state == IDLE && !startE) begin
        if (mthiE) hi <= srcaE;
        if (mtloE) lo <= srcaE;
      end else if (state == RUN && !abortE) begin
        accHi <= stepHi;
        accLo <= stepLo;
        count <= count - CW'(1);
      end else if (state == FIN && !abortE) begin
        done <= 1'b1;
        // a zero divisor returns the dividend untouched in HI and all ones in LO
        hi <= !op[1] ? prod[2*WIDTH-1:WIDTH] : (bMag == '0) ? origA : rem;
        lo <= !op[1] ? prod[WIDTH-1:0] : (bMag == '0) ? '1 : quot;
      end
    end
  end
endmodule
